// File: rtl/divider_seq_32_if.sv
// Start/operand/result bundle for the sequential 32-bit divider.
interface divider_seq_32_if;
  logic        in_start;
  logic [31:0] in_dividend;
  logic [31:0] in_divisor;
  logic        out_busy;
  logic        out_done;
  logic [31:0] out_quotient;
  logic [31:0] out_remainder;
  logic        out_div_zero;

  modport master (
    output in_start, in_dividend, in_divisor,
    input  out_busy, out_done, out_quotient, out_remainder, out_div_zero
  );

  modport slave (
    input  in_start, in_dividend, in_divisor,
    output out_busy, out_done, out_quotient, out_remainder, out_div_zero
  );
endinterface

// File: rtl/divider_seq_32.sv
// Sequential 32-bit non-restoring divider: one add/sub row iterated 32 times.
// Define DIV_SIGNED_EN for two's complement operands (truncating division).
module divider_seq_32 (
  input  logic             in_clk,
  input  logic             in_reset,
  divider_seq_32_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [32:0] a_q;
  logic [31:0] q_q, m_q;
  logic [4:0]  cnt_q;
  logic        busy_q, done_q, dz_q;
  logic [31:0] quo_q, rem_q;

  logic        start_acc, div_by_zero, row_sub;
  logic [31:0] dvd_mag, dvs_mag, quo_res, rem_res;
  logic [32:0] a_sh, a_step, a_fix;

  assign start_acc   = (state_q == IDLE) && bus.in_start;
  assign div_by_zero = (bus.in_divisor == 32'd0);

  // Single row: subtract while the partial remainder is non-negative, else add back.
  assign row_sub = ~a_q[32];
  assign a_sh    = {a_q[31:0], q_q[31]};
  assign a_step  = row_sub ? (a_sh - {1'b0, m_q}) : (a_sh + {1'b0, m_q});
  assign a_fix   = a_q[32] ? (a_q + {1'b0, m_q}) : a_q;

`ifdef DIV_SIGNED_EN
  logic neg_quo_q, neg_rem_q;
  assign dvd_mag = bus.in_dividend[31] ? (32'd0 - bus.in_dividend) : bus.in_dividend;
  assign dvs_mag = bus.in_divisor[31]  ? (32'd0 - bus.in_divisor)  : bus.in_divisor;
  // 0x80000000 / -1 falls out naturally: magnitude 0x80000000 negates to itself.
  assign quo_res = neg_quo_q ? (32'd0 - q_q) : q_q;
  assign rem_res = neg_rem_q ? (32'd0 - a_fix[31:0]) : a_fix[31:0];
`else
  assign dvd_mag = bus.in_dividend;
  assign dvs_mag = bus.in_divisor;
  assign quo_res = q_q;
  assign rem_res = a_fix[31:0];
`endif

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_acc) state_d = div_by_zero ? DONE : ITER;
      ITER: if (cnt_q == 5'd0) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      a_q    <= '0;
      q_q    <= '0;
      m_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
`ifdef DIV_SIGNED_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      // done is registered from DONE so it lands one edge after the state is entered.
      done_q <= (state_q == DONE);
      case (state_q)
        IDLE: if (start_acc) begin
          a_q    <= '0;
          q_q    <= dvd_mag;
          m_q    <= dvs_mag;
          cnt_q  <= 5'd31;
          busy_q <= 1'b1;
          dz_q   <= div_by_zero;
          if (div_by_zero) begin
            quo_q <= '1;
            rem_q <= bus.in_dividend;
          end
`ifdef DIV_SIGNED_EN
          neg_quo_q <= bus.in_dividend[31] ^ bus.in_divisor[31];
          neg_rem_q <= bus.in_dividend[31];
`endif
        end
        ITER: begin
          a_q   <= a_step;
          q_q   <= {q_q[30:0], ~a_step[32]};
          cnt_q <= cnt_q - 5'd1;
        end
        FIX: begin
          a_q   <= a_fix;
          quo_q <= quo_res;
          rem_q <= rem_res;
        end
        DONE: busy_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.out_busy      = busy_q;
  assign bus.out_done      = done_q;
  assign bus.out_div_zero  = dz_q;
  assign bus.out_quotient  = quo_q;
  assign bus.out_remainder = rem_q;
endmodule

// File: tb/tb_divider_seq_32.sv
// Bench for divider_seq_32: vector table, random vs. arithmetic model, timing corners.
module tb_divider_seq_32;
  logic in_clk = 1'b0;
  logic in_reset;
  divider_seq_32_if bus();

  divider_seq_32 dut (.in_clk(in_clk), .in_reset(in_reset), .bus(bus));

  always #5 in_clk = ~in_clk;

  int cyc = 0;
  always @(posedge in_clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] a, b, q, r;
    logic        dz;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic dz);
    if (b == 32'd0) begin
      q = '1; r = a; dz = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
`else
      q = a / b;
      r = a % b;
`endif
      dz = 1'b0;
    end
  endfunction

  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic dz,
                         output int lat, output int busy_cnt);
    bit seen;
    @(negedge in_clk);
    bus.in_start = 1'b1; bus.in_dividend = a; bus.in_divisor = b;
    @(posedge in_clk); #1;
    bus.in_start = 1'b0; bus.in_dividend = $urandom; bus.in_divisor = $urandom;
    lat = 0; busy_cnt = 0; seen = 1'b0;
    if (bus.out_busy) busy_cnt++;
    while (!seen && lat < 100) begin
      @(posedge in_clk); #1;
      lat++;
      if (bus.out_done) seen = 1'b1;
      else if (bus.out_busy) busy_cnt++;
    end
    q = bus.out_quotient; r = bus.out_remainder; dz = bus.out_div_zero;
    check("done_seen", 64'(seen), 64'd1);
    check("busy_at_done", 64'(bus.out_busy), 64'd0);
    @(posedge in_clk); #1;
    check("done_width", 64'(bus.out_done), 64'd0);
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(posedge in_clk); #1;
      if (bus.out_done) ok = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] q, r, eq, er, a, b;
    logic        dz, edz;
    int          lat, bcnt, e;
    bit          ok, saw;

    tbl[0] = '{32'd100,      32'd7,        32'd14,       32'd2,        1'b0};
    tbl[1] = '{32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0};
    tbl[2] = '{32'd5,        32'd9,        32'd0,        32'd5,        1'b0};
    tbl[3] = '{32'd1234,     32'd0,        32'hFFFFFFFF, 32'd1234,     1'b1};
`ifdef DIV_SIGNED_EN
    tbl[4] = '{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
    tbl[5] = '{32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0};
    tbl[6] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0};
`else
    tbl[4] = '{32'hFFFFFF9C, 32'd7,        32'h24924916, 32'd2,        1'b0};
    tbl[5] = '{32'd100,      32'hFFFFFFF9, 32'd0,        32'd100,      1'b0};
    tbl[6] = '{32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
`endif
    tbl[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0};
    tbl[8] = '{32'd0,        32'd5,        32'd0,        32'd0,        1'b0};
    tbl[9] = '{32'h80000000, 32'd0,        32'hFFFFFFFF, 32'h80000000, 1'b1};

    bus.in_start = 1'b0; bus.in_dividend = '0; bus.in_divisor = '0;
    in_reset = 1'b1;
    repeat (3) @(posedge in_clk);
    #1;
    check("reset_q", 64'(bus.out_quotient), 64'd0);
    check("reset_r", 64'(bus.out_remainder), 64'd0);
    check("reset_flags", 64'({bus.out_busy, bus.out_done, bus.out_div_zero}), 64'd0);
    @(negedge in_clk); in_reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_div(tbl[i].a, tbl[i].b, q, r, dz, lat, bcnt);
      check($sformatf("tbl%0d_q", i), 64'(q), 64'(tbl[i].q));
      check($sformatf("tbl%0d_r", i), 64'(r), 64'(tbl[i].r));
      check($sformatf("tbl%0d_dz", i), 64'(dz), 64'(tbl[i].dz));
      check($sformatf("tbl%0d_lat", i), 64'(lat), tbl[i].dz ? 64'd1 : 64'd34);
      check($sformatf("tbl%0d_busy", i), 64'(bcnt), tbl[i].dz ? 64'd1 : 64'd34);
    end

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = $urandom_range(1, 20);
        2: b = 32'hFFFFFFFF - $urandom_range(0, 20);
        default: b = $urandom;
      endcase
      model(a, b, eq, er, edz);
      run_div(a, b, q, r, dz, lat, bcnt);
      check($sformatf("rnd%0d_q", i), 64'(q), 64'(eq));
      check($sformatf("rnd%0d_r", i), 64'(r), 64'(er));
      check($sformatf("rnd%0d_dz", i), 64'(dz), 64'(edz));
    end

    // Reset 10 edges into an iteration: everything clears at once, no done.
    @(negedge in_clk);
    bus.in_start = 1'b1; bus.in_dividend = 32'd100; bus.in_divisor = 32'd7;
    @(posedge in_clk); #1;
    bus.in_start = 1'b0;
    repeat (10) @(posedge in_clk);
    #1; in_reset = 1'b1; #1;
    check("abort_q", 64'(bus.out_quotient), 64'd0);
    check("abort_r", 64'(bus.out_remainder), 64'd0);
    check("abort_flags", 64'({bus.out_busy, bus.out_done, bus.out_div_zero}), 64'd0);
    @(negedge in_clk); in_reset = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge in_clk); #1;
      if (bus.out_done) saw = 1'b1;
    end
    check("abort_no_done", 64'(saw), 64'd0);
    run_div(32'd100, 32'd7, q, r, dz, lat, bcnt);
    check("after_abort_q", 64'(q), 64'd14);
    check("after_abort_r", 64'(r), 64'd2);
    check("after_abort_lat", 64'(lat), 64'd34);

    // Start held high; operand change at E+5 is ignored, restart at E+35.
    @(negedge in_clk);
    bus.in_start = 1'b1; bus.in_dividend = 32'd100; bus.in_divisor = 32'd7;
    @(posedge in_clk); #1;
    e = cyc;
    repeat (5) @(posedge in_clk);
    #1; bus.in_dividend = 32'd999; bus.in_divisor = 32'd3;
    wait_done(40, ok);
    check("held1_done", 64'(ok), 64'd1);
    check("held1_time", 64'(cyc - e), 64'd34);
    check("held1_q", 64'(bus.out_quotient), 64'd14);
    check("held1_r", 64'(bus.out_remainder), 64'd2);
    wait_done(50, ok);
    check("held2_done", 64'(ok), 64'd1);
    check("held2_time", 64'(cyc - e), 64'd69);
    check("held2_q", 64'(bus.out_quotient), 64'd333);
    check("held2_r", 64'(bus.out_remainder), 64'd0);
    bus.in_start = 1'b0;
    repeat (3) @(posedge in_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/divider_seq_32.md
# divider_seq_32

Sequential 32-bit non-restoring divider for the Mini-SRC ALU `div` path. It iterates a single add/subtract row 32 times to produce the quotient and remainder. The row is the same add-or-subtract-with-carry structure used in the array divider. The quotient is written to LO and the remainder to HI by the datapath once `out_done` pulses. This replaces the 32-row combinational array, which compiles slowly and has a long critical path, with one row, a counter and a small FSM.

## Interface
- No parameters; width fixed at 32.
- in_clk  input  1  system clock; all state updates on the rising edge.
- in_reset  input  1  asynchronous, active-high reset.
- in_start  input  1  request a division; sampled only in IDLE.
- in_dividend  input  32  dividend; captured on the start edge.
- in_divisor  input  32  divisor; captured on the start edge.
- out_busy  output  1  high from the start edge until `out_done` is asserted.
- out_done  output  1  single-cycle pulse; results are valid in this cycle.
- out_quotient  output  32  quotient (to LO).
- out_remainder  output  32  remainder (to HI).
- out_div_zero  output  1  divisor was zero on the last start; held with the results.

## Operation
- Reset behaviour: asynchronous reset forces IDLE, counter = 0, and all outputs = 0.
- States:
  - IDLE: waits for `in_start`.
  - ITER: 32 steps.
  - FIX: remainder correction and sign fixup.
  - DONE: one cycle, `out_done` = 1.
  - After DONE the FSM returns to IDLE.
- Start edge, in IDLE with `in_start` = 1:
  - Latch the operands.
  - A (33-bit partial remainder) = 0; Q = dividend magnitude; M = divisor magnitude; counter = 31.
  - If divisor == 0, go directly to DONE. Otherwise go to ITER.
- ITER step:
  - Shift {A,Q} left by one.
  - If the old A[32] = 0, A = A − M (row mode = 1). Otherwise A = A + M (row mode = 0).
  - Q[0] = ~A[32] (new value).
  - Decrement the counter. Leave ITER for FIX after the step taken with counter = 0.
- FIX:
  - If A[32] = 1, A = A + M.
  - Apply the signed fixup (see Configuration).
  - Register quotient = Q and remainder = A[31:0].
- Divide by zero: quotient = 32'hFFFFFFFF, remainder = dividend as presented, `out_div_zero` = 1.
- Result hold: results and `out_div_zero` hold until the next accepted start. On the next accepted start `out_div_zero` clears.
- `in_start` outside IDLE is ignored; there is no queuing.
- Operand changes after the start edge have no effect.
- Reset asserted mid-operation aborts immediately. No `out_done` is produced.

## Timing
- Numbering: the start edge is E.
- ITER updates occur on edges E+1 through E+32, and FIX on E+33.
- `out_done` is high for exactly the cycle between E+34 and E+35. Total latency is 34 cycles from the start edge.
- Divide-by-zero case: DONE is entered at E, so `out_done` is high between E+1 and E+2.
- `out_busy` rises at E and falls at the edge where `out_done` rises.
- Back-to-back operation: `in_start` held high re-starts on the edge after DONE, i.e. E+35 in the normal case.
- Outputs are registered only; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `DIV_SIGNED_EN`.
- Defined:
  - Operands are two's complement.
  - The magnitudes are divided.
  - The quotient is negated when the operand signs differ.
  - The remainder takes the dividend's sign (truncating division).
  - 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0.
  - The divide-by-zero result is unchanged.
- Undefined:
  - Operands are unsigned.
  - There is no negation logic, and FIX performs only the remainder correction.

## Test plan
- Reset mid-ITER (cycle E+10):
  - Expect all outputs 0 and `out_busy` = 0 immediately.
  - Expect no `out_done` pulse.
  - Expect the next start to complete normally.
- 100 / 7:
  - Expect `out_done` at E+34 with quotient 14, remainder 2, `out_div_zero` = 0.
  - Expect `out_busy` high for 34 cycles.
- Unsigned build, 0xFFFFFFFF / 1:
  - Expect quotient 0xFFFFFFFF, remainder 0.
  - Also run 5 / 9 and expect quotient 0, remainder 5.
- 1234 / 0:
  - Expect `out_done` at E+1, quotient 0xFFFFFFFF, remainder 1234, `out_div_zero` = 1.
- Signed build:
  - −100 / 7: expect quotient 0xFFFFFFF2, remainder 0xFFFFFFFE.
  - 100 / −7: expect quotient 0xFFFFFFF2, remainder 2.
  - 0x80000000 / −1: expect quotient 0x80000000, remainder 0.
- `in_start` pulsed at E+5 with different operands while busy:
  - Expect them ignored and the original result delivered.
  - With `in_start` held high, expect the second division to start at E+35 and complete at E+69.
